// File: rtl/rca_word_sequencer.sv
// Wide-word add/subtract controller that reuses one N-bit ripple-carry slice over WORDS cycles,
// least-significant slice first, carrying between cycles through a carry register.

module rca_nbit_mux #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cin,
  output logic [N-1:0] o_sum,
  output logic         o_cout
);

  logic [N:0]   w_c;
  logic [N-1:0] w_p;

  assign w_c[0] = i_cin;
  assign w_p    = i_a ^ i_b;

  // Carry select: a propagating bit passes the incoming carry, otherwise a==b supplies it.
  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    assign o_sum[gi]  = w_p[gi] ^ w_c[gi];
    assign w_c[gi+1]  = w_p[gi] ? w_c[gi] : i_a[gi];
  end

  assign o_cout = w_c[N];

endmodule

module rca_word_sequencer #(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [N*WORDS-1:0] a,
  input  logic [N*WORDS-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [N*WORDS-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                    r_state;
  logic [WORDS-1:0][N-1:0]   r_a;
  logic [WORDS-1:0][N-1:0]   r_b;
  logic [WORDS-1:0][N-1:0]   r_sum;
  logic [IDXW-1:0]           r_idx;
  logic                      r_carry;
  logic                      r_cout;
  logic                      r_ovf;
  logic                      r_busy;
  logic                      r_done;

  logic [N-1:0]              w_slice_sum;
  logic                      w_slice_cout;
  logic                      w_accept;
  logic                      w_ovf_next;

  assign w_accept = (r_state == S_IDLE) && start;

  rca_nbit_mux #(.N(N)) u_slice (
    .i_a    (r_a[r_idx]),
    .i_b    (r_b[r_idx]),
    .i_cin  (r_carry),
    .o_sum  (w_slice_sum),
    .o_cout (w_slice_cout)
  );

  // Only meaningful on the last slice, where w_slice_sum[N-1] is the new result MSB.
  assign w_ovf_next = (r_a[WORDS-1][N-1] == r_b[WORDS-1][N-1]) &&
                      (w_slice_sum[N-1] != r_a[WORDS-1][N-1]);

  // NOTE: operand latches carry no reset; they are always loaded on accept before any use,
  // so resetting them would only add reset fan-out without changing behaviour.
  always_ff @(posedge clk) begin
    if (rst_n && w_accept) begin
      r_a <= a;
      r_b <= sub ? ~b : b;
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register samples
  // pre-edge values, regardless of statement order within the block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
          if (start) begin
            r_carry <= sub ? 1'b1 : cin;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end

        S_RUN: begin
          r_sum[r_idx] <= w_slice_sum;
          r_carry      <= w_slice_cout;
          if (r_idx == LAST_IDX) begin
            r_cout  <= w_slice_cout;
            r_ovf   <= w_ovf_next;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule
